// File: rtl/pru_cmd_queue.sv
// pru_cmd_queue: memory-mapped draw-command FIFO that feeds the pixel render unit.
// CPU stages POS/SIZE, a GO write commits a command, and the issue FSM runs the PRU start/done handshake.
`default_nettype none

module pru_cmd_queue #(
    parameter int unsigned DEPTH = 8,
    parameter logic [31:0] BASE  = 32'h4010
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] bus_addr,
    input  logic [31:0] bus_wdata,
    input  logic        bus_we,
    input  logic        bus_re,
    output logic [31:0] bus_rdata,
    input  logic        pru_busy,
    input  logic        pru_done,
    output logic        pru_start,
    output logic [1:0]  pru_shape,
    output logic [1:0]  pru_color,
    output logic [9:0]  pru_row,
    output logic [8:0]  pru_col,
    output logic [9:0]  pru_width,
    output logic [8:0]  pru_hr,
    output logic        irq
);
    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH) + 1;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ISSUE   = 2'd1,
        S_RELEASE = 2'd2
    } state_t;

    state_t         state_q, state_d;
    logic [9:0]     pos_row_q, pos_row_d;
    logic [8:0]     pos_col_q, pos_col_d;
    logic [9:0]     size_w_q, size_w_d;
    logic [8:0]     size_hr_q, size_hr_d;
    logic           ovf_q, ovf_d, err_q, err_d, irq_en_q, irq_en_d;
    logic [AW-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]  count_q, count_d;
    logic [41:0]    fields_q, fields_d;
    logic [31:0]    rdata_q, rdata_d;
    logic [41:0]    mem_q [DEPTH];

    logic        hit_pos, hit_size, hit_go, hit_ctrl;
    logic        go_wr, ctrl_wr, go_bad, full, empty, pop, push, flush;
    logic [41:0] push_data;
    logic [31:0] status;

    always_comb begin
        hit_pos   = (bus_addr == BASE);
        hit_size  = (bus_addr == BASE + 32'h4);
        hit_go    = (bus_addr == BASE + 32'h8);
        hit_ctrl  = (bus_addr == BASE + 32'hC);
        go_wr     = bus_we && hit_go;
        ctrl_wr   = bus_we && hit_ctrl;
        flush     = ctrl_wr && bus_wdata[0];
        // Zero width is only meaningless for rectangles; a circle uses height_radius alone.
        go_bad    = (size_hr_q == 9'd0) || ((bus_wdata[3:2] == 2'b00) && (size_w_q == 10'd0));
        full      = (count_q == CW'(DEPTH));
        empty     = (count_q == '0);
        pop       = (state_q == S_IDLE) && !empty && !pru_busy && !pru_done;
        push      = go_wr && !go_bad && (!full || pop || flush);
        push_data = {bus_wdata[3:2], bus_wdata[1:0], pos_row_q, pos_col_q, size_w_q, size_hr_q};

        status        = '0;
        status[6:0]   = 7'(count_q);
        status[8]     = full;
        status[9]     = empty;
        status[10]    = ovf_q;
        status[11]    = err_q;
        status[12]    = (state_q != S_IDLE);
        status[13]    = irq_en_q;

        pos_row_d = pos_row_q;
        pos_col_d = pos_col_q;
        size_w_d  = size_w_q;
        size_hr_d = size_hr_q;
        if (bus_we && hit_pos) begin
            pos_row_d = bus_wdata[9:0];
            pos_col_d = bus_wdata[24:16];
        end
        if (bus_we && hit_size) begin
            size_w_d  = bus_wdata[9:0];
            size_hr_d = bus_wdata[24:16];
        end

        ovf_d    = ovf_q | (go_wr && !go_bad && full && !pop && !flush);
        err_d    = err_q | (go_wr && go_bad);
        irq_en_d = irq_en_q;
        if (ctrl_wr) begin
            if (bus_wdata[1]) ovf_d = 1'b0;
            if (bus_wdata[2]) err_d = 1'b0;
            irq_en_d = bus_wdata[3];
        end

        // A flush discards everything queued; a GO in the same cycle lands in the emptied FIFO.
        if (flush) begin
            rd_ptr_d = wr_ptr_q;
            wr_ptr_d = wr_ptr_q + AW'(push);
            count_d  = CW'(push);
        end else begin
            rd_ptr_d = rd_ptr_q + AW'(pop);
            wr_ptr_d = wr_ptr_q + AW'(push);
            count_d  = count_q + CW'(push) - CW'(pop);
        end

        fields_d = pop ? mem_q[rd_ptr_q] : fields_q;

        rdata_d = rdata_q;
        if (bus_re) rdata_d = hit_ctrl ? status : 32'd0;

        state_d = state_q;
        case (state_q)
            S_IDLE:    if (pop) state_d = S_ISSUE;
            S_ISSUE:   if (pru_done) state_d = S_RELEASE;
            S_RELEASE: if (!pru_done && !pru_busy) state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            pos_row_q <= '0;
            pos_col_q <= '0;
            size_w_q  <= '0;
            size_hr_q <= '0;
            ovf_q     <= 1'b0;
            err_q     <= 1'b0;
            irq_en_q  <= 1'b0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            fields_q  <= '0;
            rdata_q   <= '0;
        end else begin
            state_q   <= state_d;
            pos_row_q <= pos_row_d;
            pos_col_q <= pos_col_d;
            size_w_q  <= size_w_d;
            size_hr_q <= size_hr_d;
            ovf_q     <= ovf_d;
            err_q     <= err_d;
            irq_en_q  <= irq_en_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            fields_q  <= fields_d;
            rdata_q   <= rdata_d;
        end
    end

    // Storage needs no reset: occupancy is tracked by the pointers and count.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= push_data;
    end

    assign {pru_shape, pru_color, pru_row, pru_col, pru_width, pru_hr} = fields_q;
    assign pru_start = (state_q == S_ISSUE);
    assign irq       = empty && (state_q == S_IDLE) && irq_en_q;
    assign bus_rdata = rdata_q;

    logic unused_wdata;
    assign unused_wdata = &{1'b0, bus_wdata[31:25], bus_wdata[15:10]};

endmodule

`default_nettype wire

// File: tb/tb_pru_cmd_queue.sv
// tb_pru_cmd_queue: scoreboard bench for pru_cmd_queue with a behavioural PRU busy/done model.
`default_nettype none
`timescale 1ns/1ps

module tb_pru_cmd_queue;
    localparam logic [31:0] BASE = 32'h4010;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] bus_addr, bus_wdata, bus_rdata;
    logic        bus_we, bus_re;
    logic        pru_busy, pru_done, pru_start, irq;
    logic [1:0]  pru_shape, pru_color;
    logic [9:0]  pru_row, pru_width;
    logic [8:0]  pru_col, pru_hr;

    pru_cmd_queue #(.DEPTH(8), .BASE(BASE)) dut (
        .clk(clk), .rst(rst),
        .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_we(bus_we), .bus_re(bus_re),
        .bus_rdata(bus_rdata),
        .pru_busy(pru_busy), .pru_done(pru_done), .pru_start(pru_start),
        .pru_shape(pru_shape), .pru_color(pru_color), .pru_row(pru_row), .pru_col(pru_col),
        .pru_width(pru_width), .pru_hr(pru_hr), .irq(irq)
    );

    always #5 clk = ~clk;

    int          n_cmp = 0;
    int          n_bad = 0;
    logic [41:0] sb[$];
    bit          pru_stall = 1'b0;
    int          draw_len = 10;
    int          start_rises = 0;
    int          low_gap = 0;
    bit          had_pulse = 1'b0;
    logic [41:0] cur_exp = '0;
    logic        prev_start = 1'b0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic bus_write(input logic [31:0] off, input logic [31:0] data);
        bus_addr  = BASE + off;
        bus_wdata = data;
        bus_we    = 1'b1;
        @(posedge clk); #1;
        bus_we    = 1'b0;
    endtask

    task automatic bus_read(input logic [31:0] off, output logic [31:0] data);
        bus_addr = BASE + off;
        bus_re   = 1'b1;
        @(posedge clk); #1;
        bus_re   = 1'b0;
        data     = bus_rdata;
    endtask

    task automatic go(input logic [9:0] row, input logic [8:0] col, input logic [9:0] w,
                      input logic [8:0] hr, input logic [1:0] shape, input logic [1:0] color,
                      input bit accept);
        if (accept) sb.push_back({shape, color, row, col, w, hr});
        bus_write(32'h0, {7'd0, col, 6'd0, row});
        bus_write(32'h4, {7'd0, hr, 6'd0, w});
        bus_write(32'h8, {28'd0, shape, color});
    endtask

    task automatic wait_idle(input string tag);
        int k = 0;
        while ((sb.size() != 0 || pru_start || pru_busy || pru_done) && k < 2000) begin
            @(posedge clk); #1;
            k++;
        end
        if (k >= 2000) chk(tag, 64'(k), 64'(0));
        repeat (3) @(posedge clk);
        #1;
    endtask

    // PRU model: latches a start, stays busy for draw_len cycles, then pulses done.
    initial begin
        pru_busy = 1'b0;
        pru_done = 1'b0;
        forever begin
            @(negedge clk);
            if (pru_start && !pru_stall) begin
                pru_busy = 1'b1;
                repeat (draw_len) @(negedge clk);
                pru_busy = 1'b0;
                pru_done = 1'b1;
                @(negedge clk);
                pru_done = 1'b0;
            end
        end
    end

    // Scoreboard monitor: each start rising edge pops one expected command.
    initial begin
        logic [41:0] obs;
        forever begin
            @(negedge clk);
            obs = {pru_shape, pru_color, pru_row, pru_col, pru_width, pru_hr};
            if (pru_start && !prev_start) begin
                start_rises++;
                if (had_pulse) chk("start_gap_ge2", 64'(low_gap >= 2), 64'(1));
                if (sb.size() == 0) begin
                    chk("unexpected_start", 64'(sb.size()), 64'(1));
                    cur_exp = obs;
                end else begin
                    cur_exp = sb.pop_front();
                    chk("issue_fields", 64'(obs), 64'(cur_exp));
                end
                had_pulse = 1'b1;
            end else if (pru_start) begin
                chk("fields_stable", 64'(obs), 64'(cur_exp));
            end
            low_gap    = pru_start ? 0 : low_gap + 1;
            prev_start = pru_start;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1);
    end

    initial begin
        logic [31:0] rd;
        int          r0, k;
        rst = 1'b1; bus_addr = '0; bus_wdata = '0; bus_we = 1'b0; bus_re = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // Reset state
        chk("reset_outputs", 64'({pru_start, pru_shape, pru_color, pru_row, pru_col,
                                   pru_width, pru_hr, irq, bus_rdata}), 64'(0));
        bus_read(32'hC, rd);
        chk("reset_status", 64'(rd), 64'(32'h200));
        bus_read(32'h0, rd);
        chk("pos_reads_zero", 64'(rd), 64'(0));

        // Single rect; start two cycles after GO, held until done
        draw_len = 30;
        go(10'd50, 9'd20, 10'd40, 9'd10, 2'b00, 2'b01, 1'b1);
        chk("start_not_yet", 64'(pru_start), 64'(0));
        @(posedge clk); #1;
        chk("start_after_2", 64'(pru_start), 64'(1));
        k = 0;
        while (!pru_done && k < 200) begin
            @(negedge clk); #1;
            k++;
        end
        chk("done_seen", 64'(pru_done), 64'(1));
        chk("start_held_at_done", 64'(pru_start), 64'(1));
        @(posedge clk); #1;
        chk("start_falls", 64'(pru_start), 64'(0));
        wait_idle("drain_single");

        // Three circles in FIFO order
        draw_len = 10;
        r0 = start_rises;
        go(10'd100, 9'd30, 10'd0,  9'd7,  2'b01, 2'b10, 1'b1);
        go(10'd200, 9'd60, 10'd5,  9'd12, 2'b01, 2'b11, 1'b1);
        go(10'd300, 9'd90, 10'd9,  9'd3,  2'b01, 2'b00, 1'b1);
        wait_idle("drain_circles");
        chk("circle_pulses", 64'(start_rises - r0), 64'(3));

        // Interrupt enable while empty and idle
        bus_write(32'hC, 32'h8);
        chk("irq_level", 64'(irq), 64'(1));
        bus_read(32'hC, rd);
        chk("status_irq_en", 64'(rd), 64'(32'h2200));

        // Overflow with a stalled PRU
        pru_stall = 1'b1;
        r0 = start_rises;
        for (int i = 0; i < 9; i++)
            go(10'(i + 1), 9'(i * 3), 10'(i + 4), 9'(i + 2), 2'(i % 2), 2'(i), 1'b1);
        bus_read(32'hC, rd);
        chk("status_full", 64'(rd), 64'(32'h3108));
        chk("irq_busy", 64'(irq), 64'(0));
        go(10'd9, 9'd9, 10'd9, 9'd9, 2'b00, 2'b00, 1'b0);
        bus_read(32'hC, rd);
        chk("status_ovf", 64'(rd), 64'(32'h3508));
        bus_write(32'hC, 32'hA);
        bus_read(32'hC, rd);
        chk("status_ovf_clr", 64'(rd), 64'(32'h3108));
        pru_stall = 1'b0;
        wait_idle("drain_ovf");
        chk("ovf_pulses", 64'(start_rises - r0), 64'(9));

        // Geometry filtering
        go(10'd1, 9'd1, 10'd0, 9'd5, 2'b00, 2'b01, 1'b0);
        bus_read(32'hC, rd);
        chk("status_err_rect", 64'(rd), 64'(32'h2A00));
        go(10'd2, 9'd2, 10'd0, 9'd5, 2'b01, 2'b10, 1'b1);
        wait_idle("drain_circle_w0");
        bus_read(32'hC, rd);
        chk("status_err_sticky", 64'(rd), 64'(32'h2A00));
        bus_write(32'hC, 32'hC);
        bus_read(32'hC, rd);
        chk("status_err_clr", 64'(rd), 64'(32'h2200));
        go(10'd3, 9'd3, 10'd5, 9'd0, 2'b01, 2'b01, 1'b0);
        bus_read(32'hC, rd);
        chk("status_err_hr0", 64'(rd), 64'(32'h2A00));
        bus_write(32'hC, 32'hC);

        // Flush with one in flight and four queued
        pru_stall = 1'b1;
        for (int i = 0; i < 5; i++)
            go(10'(i + 20), 9'(i + 40), 10'(i + 1), 9'(i + 1), 2'b00, 2'(i), 1'b1);
        bus_read(32'hC, rd);
        chk("status_pre_flush", 64'(rd), 64'(32'h3004));
        bus_write(32'hC, 32'h9);
        bus_read(32'hC, rd);
        chk("status_flushed", 64'(rd), 64'(32'h3200));
        sb.delete();
        r0 = start_rises;
        pru_stall = 1'b0;
        wait_idle("drain_flush");
        repeat (20) @(posedge clk);
        #1;
        chk("no_start_after_flush", 64'(start_rises - r0), 64'(0));
        bus_read(32'hC, rd);
        chk("status_after_flush", 64'(rd), 64'(32'h2200));

        // Asynchronous reset mid-ISSUE
        pru_stall = 1'b1;
        go(10'd7, 9'd8, 10'd9, 9'd10, 2'b01, 2'b11, 1'b1);
        repeat (3) @(posedge clk);
        #1;
        chk("start_before_rst", 64'(pru_start), 64'(1));
        #2 rst = 1'b1;
        #1;
        chk("rst_async_start", 64'(pru_start), 64'(0));
        sb.delete();
        pru_stall = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("rst_outputs", 64'({pru_start, pru_shape, pru_color, pru_row, pru_col,
                                 pru_width, pru_hr, irq}), 64'(0));
        bus_read(32'hC, rd);
        chk("rst_status", 64'(rd), 64'(32'h200));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/pru_cmd_queue.md
# pru_cmd_queue

Memory-mapped command front end that sits directly upstream of the pixel render unit (PRU). The CPU writes draw commands (position, size, colour index, shape) into register slots. The commit write pushes the assembled command into a FIFO. An issue state machine pops commands one at a time and drives the PRU `start`/shape/geometry inputs, honouring its `busy`/`done` handshake. This lets software queue several shapes without polling the PRU between them.

## Interface
Parameters:
- `DEPTH`, default 8: FIFO entries; power of two, 2..64.
- `BASE`, default 32'h4010: byte address of the first register. Palette writes at 0x4000–0x400C bypass this block.

Ports:
- `clk` in 1: single clock for all logic.
- `rst` in 1: reset, asynchronous and active-high.
- `bus_addr` in 32: CPU byte address.
- `bus_wdata` in 32: CPU write data.
- `bus_we` in 1: one-cycle write strobe.
- `bus_re` in 1: one-cycle read strobe.
- `bus_rdata` out 32: read data, registered.
- `pru_busy` in 1: PRU `busy`.
- `pru_done` in 1: PRU `done`.
- `pru_start` out 1: PRU `start`.
- `pru_shape` out 2: PRU `shape_select`; 00 = rect, 01 = circle.
- `pru_color` out 2: PRU `color`.
- `pru_row` out 10: PRU `row`.
- `pru_col` out 9: PRU `col`.
- `pru_width` out 10: PRU `width`.
- `pru_hr` out 9: PRU `height_radius`.
- `irq` out 1: level interrupt; high while the FIFO is empty, the FSM is IDLE and `irq_en` is set.

## Operation
Registers (word offsets from `BASE`):
- +0x0 POS: [9:0] row, [24:16] col.
- +0x4 SIZE: [9:0] width, [24:16] height_radius.
- +0x8 GO: [1:0] colour, [3:2] shape. A write commits {shape, colour, POS, SIZE} as a 42-bit entry. POS and SIZE are staging registers; they persist across commits.
- +0xC CTRL/STATUS.
  - Write: bit0 flush FIFO, bit1 clear `ovf`, bit2 clear `err`, bit3 `irq_en`.
  - Read: [6:0] count, bit8 full, bit9 empty, bit10 `ovf`, bit11 `err`, bit12 issuing (FSM not IDLE), bit13 `irq_en`.

Commit filtering:
- A GO write with width==0 (rect only) or height_radius==0 is discarded and sets sticky `err`.
- A GO write when full and no pop in the same cycle is discarded and sets sticky `ovf`.
- A push and a pop in the same cycle are both performed; count is unchanged.

Flush:
- Empties the FIFO (count→0).
- Does not abort an in-flight command.
- A GO in the same cycle as a flush is pushed after the flush, so count = 1.

Issue FSM:
- IDLE: if the FIFO is not empty and `pru_busy`==0 and `pru_done`==0, pop the head, load all `pru_*` field registers, and go to ISSUE.
- ISSUE: `pru_start`=1. When `pru_done`==1, go to RELEASE.
- RELEASE: `pru_start`=0. When `pru_done`==0 and `pru_busy`==0, go to IDLE.

Field outputs are held constant from the load until the next load, because the PRU uses them combinationally throughout the draw.

Reads: `bus_rdata` updates on the edge after `bus_re`. Unmapped addresses, and POS/SIZE/GO, read as 0.

## Timing
Reset values:
- All outputs are 0.
- FSM is IDLE, count = 0.
- Staging registers, `ovf`, `err` and `irq_en` are 0.

Latency:
- GO written at edge N: entry is visible (count = 1) after N.
- The FSM pops at edge N+1; `pru_start` and fields are valid after N+1.
- Best-case latency from GO to `pru_start` is 2 cycles.

Handshake:
- `pru_start` is never high while in RELEASE or IDLE.
- Back-to-back commands need at least two cycles of `pru_start` low between them: one in RELEASE and one in IDLE.

Boundaries:
- Count saturates at `DEPTH`; pointers wrap modulo `DEPTH`.
- `rst` asserted mid-draw drops `pru_start` immediately (asynchronous) and empties the FIFO.

## Test plan
- Reset, then read STATUS → rdata = 0x200 (empty). All `pru_*` outputs are 0.
- Write POS = 0x0014_0032, SIZE = 0x000A_0028, GO = 0x1 → `pru_start` rises 2 cycles after GO with row = 50, col = 20, width = 40, hr = 10, shape = 0, color = 1. Model PRU `done` 30 cycles later → `start` falls the next cycle.
- Queue 3 circles, each with a 10-cycle model draw → three `start` pulses in FIFO order, at least 2 low cycles apart, fields stable while `start` is high.
- With the PRU model stalled, issue 9 GOs at DEPTH = 8 → one enters the PRU, 8 are queued, `ovf` = 0. A 10th GO → `ovf` = 1 and count stays 8. CTRL = 0x2 → `ovf` = 0.
- GO with SIZE width = 0, shape = rect → count unchanged, `err` = 1. The same with a circle and width = 0, hr = 5 → accepted.
- Flush while a command is in flight and 4 are queued → count = 0, the current command completes normally, no further `start`. Assert `rst` mid-ISSUE → `start` = 0 the same cycle.
